// File: rtl/inbox_ctl.sv
// Inbox sequencing controller: buffers a loader list, then serves it word by word to the CPU.
// Optional replay of the committed list via `rewind`, enabled by defining INBOX_REWIND_EN.
module inbox_ctl #(
    parameter int DEPTH_LOG2 = 5,
    parameter int WIDTH      = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ld_valid,
    input  logic [WIDTH-1:0]      ld_data,
    input  logic                  ld_last,
    output logic                  ld_ready,
    input  logic                  rIn,
    output logic [WIDTH-1:0]      DIN,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overflow
`ifdef INBOX_REWIND_EN
    ,
    input  logic                  rewind
`endif
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL = (DEPTH_LOG2 + 1)'(DEPTH);

    localparam logic [0:0] LOAD  = 1'b0;
    localparam logic [0:0] SERVE = 1'b1;

    logic [0:0]            state;
    logic [DEPTH_LOG2:0]   wr_ptr;
    logic [DEPTH_LOG2:0]   rd_ptr;
    logic                  ovf_q;
    logic [WIDTH-1:0]      mem [DEPTH];

    always_comb begin
        ld_ready = (state == LOAD);
        empty    = (state == LOAD) || (rd_ptr == wr_ptr);
        DIN      = empty ? '0 : mem[rd_ptr[DEPTH_LOG2-1:0]];
        count    = (state == LOAD) ? wr_ptr : (wr_ptr - rd_ptr);
        overflow = ovf_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= LOAD;
            wr_ptr <= '0;
            rd_ptr <= '0;
            ovf_q  <= 1'b0;
        end else begin
            case (state)
                LOAD: begin
                    if (ld_valid) begin
                        if (wr_ptr != FULL) wr_ptr <= wr_ptr + 1'b1;
                        else                ovf_q  <= 1'b1;
                        // a dropped last word still commits the list
                        if (ld_last) begin
                            state  <= SERVE;
                            rd_ptr <= '0;
                        end
                    end
                end
                default: begin
                    // the reload-request word itself is taken next cycle in LOAD
                    if (empty && ld_valid) begin
                        state  <= LOAD;
                        wr_ptr <= '0;
                        rd_ptr <= '0;
                        ovf_q  <= 1'b0;
                    end
`ifdef INBOX_REWIND_EN
                    else if (rewind) begin
                        rd_ptr <= '0;
                    end
`endif
                    else if (rIn && !empty) begin
                        rd_ptr <= rd_ptr + 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && state == LOAD && ld_valid && wr_ptr != FULL)
            mem[wr_ptr[DEPTH_LOG2-1:0]] <= ld_data;
    end

endmodule

// File: tb/tb_inbox_ctl.sv
// Scoreboard bench for inbox_ctl (4-word buffer): stimulus queues expected outputs,
// a negedge monitor pops and compares them.
module tb_inbox_ctl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ld_valid = 1'b0;
    logic [7:0] ld_data = 8'h00;
    logic       ld_last = 1'b0;
    logic       ld_ready;
    logic       rin = 1'b0;
    logic [7:0] din;
    logic       empty;
    logic [2:0] count;
    logic       overflow;
    logic       rewind_s = 1'b0;

    int applied = 0;
    int miscompares = 0;

    typedef struct packed {
        logic [7:0] din;
        logic       emp;
        logic [2:0] cnt;
        logic       ovf;
        logic       rdy;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];

    always #5 clk = ~clk;

    inbox_ctl #(.DEPTH_LOG2(2), .WIDTH(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .ld_valid (ld_valid),
        .ld_data  (ld_data),
        .ld_last  (ld_last),
        .ld_ready (ld_ready),
        .rIn      (rin),
        .DIN      (din),
        .empty    (empty),
        .count    (count),
        .overflow (overflow)
`ifdef INBOX_REWIND_EN
        ,
        .rewind   (rewind_s)
`endif
    );

    task automatic cyc(input logic v, input logic [7:0] d, input logic l,
                       input logic r, input logic rw);
        ld_valid = v; ld_data = d; ld_last = l; rin = r; rewind_s = rw;
        @(posedge clk);
        #1;
        ld_valid = 1'b0; ld_last = 1'b0; rin = 1'b0; rewind_s = 1'b0;
    endtask

    task automatic ex(input string n, input logic [7:0] d, input logic e,
                      input logic [2:0] c, input logic o, input logic r);
        exp_t x;
        x.din = d; x.emp = e; x.cnt = c; x.ovf = o; x.rdy = r;
        exp_q.push_back(x);
        name_q.push_back(n);
    endtask

    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            exp_t  x;
            string n;
            x = exp_q.pop_front();
            n = name_q.pop_front();
            applied++;
            if (din !== x.din) begin
                miscompares++;
                $display("FAIL %s DIN got %02h want %02h", n, din, x.din);
            end
            applied++;
            if (empty !== x.emp) begin
                miscompares++;
                $display("FAIL %s empty got %0b want %0b", n, empty, x.emp);
            end
            applied++;
            if (count !== x.cnt) begin
                miscompares++;
                $display("FAIL %s count got %0d want %0d", n, count, x.cnt);
            end
            applied++;
            if (overflow !== x.ovf) begin
                miscompares++;
                $display("FAIL %s overflow got %0b want %0b", n, overflow, x.ovf);
            end
            applied++;
            if (ld_ready !== x.rdy) begin
                miscompares++;
                $display("FAIL %s ld_ready got %0b want %0b", n, ld_ready, x.rdy);
            end
        end
    end

    initial begin
        //                 name        DIN    emp cnt ovf rdy
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        ex("reset",       8'h00, 1, 0, 0, 1);

        // basic load with rIn held during LOAD (must be ignored)
        cyc(1, 8'h11, 0, 1, 0); ex("ld0",         8'h00, 1, 1, 0, 1);
        cyc(1, 8'h22, 0, 1, 0); ex("ld1",         8'h00, 1, 2, 0, 1);
        cyc(1, 8'h33, 1, 0, 0); ex("ld_last",     8'h11, 0, 3, 0, 0);
        // loader word while not empty is held off
        cyc(1, 8'h77, 1, 1, 0); ex("rd0",         8'h22, 0, 2, 0, 0);
        cyc(0, 8'h00, 0, 1, 0); ex("rd1",         8'h33, 0, 1, 0, 0);
        cyc(0, 8'h00, 0, 1, 0); ex("rd2",         8'h00, 1, 0, 0, 0);
        cyc(0, 8'h00, 0, 1, 0); ex("rd_empty",    8'h00, 1, 0, 0, 0);
        cyc(0, 8'h00, 0, 1, 0); ex("rd_empty2",   8'h00, 1, 0, 0, 0);

        // overflow: first ld_valid only re-arms LOAD, then 5 words into 4 slots
        cyc(1, 8'h01, 0, 0, 0); ex("ov_rearm",    8'h00, 1, 0, 0, 1);
        cyc(1, 8'h01, 0, 0, 0); ex("ov1",         8'h00, 1, 1, 0, 1);
        cyc(1, 8'h02, 0, 0, 0); ex("ov2",         8'h00, 1, 2, 0, 1);
        cyc(1, 8'h03, 0, 0, 0); ex("ov3",         8'h00, 1, 3, 0, 1);
        cyc(1, 8'h04, 0, 0, 0); ex("ov4",         8'h00, 1, 4, 0, 1);
        cyc(1, 8'h05, 1, 0, 0); ex("ov_last",     8'h01, 0, 4, 1, 0);
        cyc(0, 8'h00, 0, 1, 0); ex("ov_rd1",      8'h02, 0, 3, 1, 0);
        cyc(0, 8'h00, 0, 1, 0); ex("ov_rd2",      8'h03, 0, 2, 1, 0);
        cyc(0, 8'h00, 0, 1, 0); ex("ov_rd3",      8'h04, 0, 1, 1, 0);
        cyc(0, 8'h00, 0, 1, 0); ex("ov_rd4",      8'h00, 1, 0, 1, 0);

        // reload clears overflow; word accepted one cycle after the request
        cyc(1, 8'hAA, 1, 0, 0); ex("rl_rearm",    8'h00, 1, 0, 0, 1);
        cyc(1, 8'hAA, 1, 0, 0); ex("rl_take",     8'hAA, 0, 1, 0, 0);
        cyc(0, 8'h00, 0, 1, 0); ex("rl_rd",       8'h00, 1, 0, 0, 0);

        // reset mid-serve wins over simultaneous inputs
        cyc(1, 8'h44, 0, 0, 0); ex("mr_rearm",    8'h00, 1, 0, 0, 1);
        cyc(1, 8'h44, 0, 0, 0); ex("mr_ld0",      8'h00, 1, 1, 0, 1);
        cyc(1, 8'h55, 0, 0, 0); ex("mr_ld1",      8'h00, 1, 2, 0, 1);
        cyc(1, 8'h66, 1, 0, 0); ex("mr_ld2",      8'h44, 0, 3, 0, 0);
        cyc(0, 8'h00, 0, 1, 0); ex("mr_rd",       8'h55, 0, 2, 0, 0);
        rst = 1'b1;
        cyc(1, 8'h99, 1, 1, 0); ex("mr_reset",    8'h00, 1, 0, 0, 1);
        rst = 1'b0;

`ifdef INBOX_REWIND_EN
        cyc(1, 8'h11, 0, 0, 0); ex("rw_ld0",      8'h00, 1, 1, 0, 1);
        cyc(1, 8'h22, 0, 0, 0); ex("rw_ld1",      8'h00, 1, 2, 0, 1);
        cyc(1, 8'h33, 1, 0, 0); ex("rw_ld2",      8'h11, 0, 3, 0, 0);
        cyc(0, 8'h00, 0, 1, 0); ex("rw_rd0",      8'h22, 0, 2, 0, 0);
        cyc(0, 8'h00, 0, 1, 0); ex("rw_rd1",      8'h33, 0, 1, 0, 0);
        cyc(0, 8'h00, 0, 1, 1); ex("rw_rewind",   8'h11, 0, 3, 0, 0);
`else
        // after reset, a fresh list starts at slot 0
        cyc(1, 8'hBB, 1, 0, 0); ex("post_rst",    8'hBB, 0, 1, 0, 0);
`endif

        repeat (3) @(posedge clk);
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain queue left %0d want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule
